// File: rtl/voice_allocator.sv
// Polyphonic voice allocator: a small FIFO buffers 16-bit note commands, then each command is
// run through a one-voice-per-cycle scan and a single apply cycle (match, else free, else steal oldest).
`timescale 1ns/1ps
module voice_allocator #(
  parameter int NUM_VOICES = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int AGE_W      = 6
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    cmd_write,
  input  logic [15:0]             cmd_data,
  input  logic                    ovf_clear,
  output logic                    busy,
  output logic                    overflow,
  output logic [NUM_VOICES-1:0]   voice_gate,
  output logic [7*NUM_VOICES-1:0] voice_note,
  output logic [8*NUM_VOICES-1:0] voice_vel,
  output logic [NUM_VOICES-1:0]   voice_retrig,
  output logic                    steal
);

  localparam int IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [IDX_W-1:0] LAST_IDX      = IDX_W'(NUM_VOICES - 1);
  localparam logic [CNT_W-1:0] FIFO_FULL_CNT = CNT_W'(FIFO_DEPTH);
  localparam logic [AGE_W-1:0] AGE_MAX       = '1;
  localparam logic [6:0]       STOP_ALL_NOTE = 7'd127;

  typedef enum logic [1:0] {IDLE, SCAN, APPLY} state_e;

  // Command FIFO
  logic [15:0]      fifo_mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             overflow_q, overflow_d;
  logic             fifo_empty, fifo_full, push, pop;
  logic [15:0]      fifo_head;
  logic             head_is_stop_all;

  // Scheduler
  state_e           state_q, state_d;
  logic [15:0]      cmd_q, cmd_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             match_vld_q, match_vld_d;
  logic [IDX_W-1:0] match_idx_q, match_idx_d;
  logic             free_vld_q, free_vld_d;
  logic [IDX_W-1:0] free_idx_q, free_idx_d;
  logic             oldest_vld_q, oldest_vld_d;
  logic [IDX_W-1:0] oldest_idx_q, oldest_idx_d;
  logic [AGE_W-1:0] oldest_age_q, oldest_age_d;
  logic             cmd_start, cmd_stop_all;
  logic [6:0]       cmd_note;
  logic [7:0]       cmd_vel;
  logic [IDX_W-1:0] target;

  // Voice state
  logic [NUM_VOICES-1:0] gate_q, gate_d;
  logic [6:0]            note_q [NUM_VOICES];
  logic [6:0]            note_d [NUM_VOICES];
  logic [7:0]            vel_q  [NUM_VOICES];
  logic [7:0]            vel_d  [NUM_VOICES];
  logic [AGE_W-1:0]      age_q  [NUM_VOICES];
  logic [AGE_W-1:0]      age_d  [NUM_VOICES];
  logic [NUM_VOICES-1:0] retrig_q, retrig_d;
  logic                  steal_q, steal_d;

  assign fifo_empty       = (count_q == '0);
  assign fifo_full        = (count_q == FIFO_FULL_CNT);
  assign fifo_head        = fifo_mem_q[rd_ptr_q];
  assign head_is_stop_all = !fifo_head[15] && (fifo_head[14:8] == STOP_ALL_NOTE);
  assign pop              = (state_q == IDLE) && !fifo_empty;
  // A full FIFO still accepts a write when the scheduler drains an entry in the same cycle.
  assign push             = cmd_write && (!fifo_full || pop);

  assign cmd_start    = cmd_q[15];
  assign cmd_note     = cmd_q[14:8];
  assign cmd_vel      = cmd_q[7:0];
  assign cmd_stop_all = !cmd_start && (cmd_note == STOP_ALL_NOTE);
  assign target       = match_vld_q ? match_idx_q : (free_vld_q ? free_idx_q : oldest_idx_q);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    // A dropped write outranks a clear arriving in the same cycle.
    if (cmd_write && !push) overflow_d = 1'b1;
    else if (ovf_clear)     overflow_d = 1'b0;
    else                    overflow_d = overflow_q;
  end

  // NOTE: FIFO storage has no reset; an entry is only read after it was written, and count_q guards that.
  always_ff @(posedge clk) begin
    if (push) fifo_mem_q[wr_ptr_q] <= cmd_data;
  end

  always_comb begin
    // NOTE: every _d first takes a hold value so no branch below can infer a latch.
    state_d      = state_q;
    cmd_d        = cmd_q;
    idx_d        = idx_q;
    match_vld_d  = match_vld_q;
    match_idx_d  = match_idx_q;
    free_vld_d   = free_vld_q;
    free_idx_d   = free_idx_q;
    oldest_vld_d = oldest_vld_q;
    oldest_idx_d = oldest_idx_q;
    oldest_age_d = oldest_age_q;
    gate_d       = gate_q;
    note_d       = note_q;
    vel_d        = vel_q;
    age_d        = age_q;
    retrig_d     = '0;
    steal_d      = 1'b0;

    case (state_q)
      IDLE: begin
        if (pop) begin
          cmd_d        = fifo_head;
          idx_d        = '0;
          match_vld_d  = 1'b0;
          free_vld_d   = 1'b0;
          oldest_vld_d = 1'b0;
          state_d      = head_is_stop_all ? APPLY : SCAN;
        end
      end

      SCAN: begin
        if (gate_q[idx_q]) begin
          if (!match_vld_q && (note_q[idx_q] == cmd_note)) begin
            match_vld_d = 1'b1;
            match_idx_d = idx_q;
          end
          // Strict greater-than keeps the lowest index on equal ages.
          if (!oldest_vld_q || (age_q[idx_q] > oldest_age_q)) begin
            oldest_vld_d = 1'b1;
            oldest_idx_d = idx_q;
            oldest_age_d = age_q[idx_q];
          end
        end else if (!free_vld_q) begin
          free_vld_d = 1'b1;
          free_idx_d = idx_q;
        end
        if (idx_q == LAST_IDX) state_d = APPLY;
        else                   idx_d   = idx_q + 1'b1;
      end

      APPLY: begin
        state_d = IDLE;
        if (cmd_stop_all) begin
          gate_d = '0;
          for (int i = 0; i < NUM_VOICES; i++) age_d[i] = '0;
        end else if (!cmd_start) begin
          if (match_vld_q) begin
            gate_d[match_idx_q] = 1'b0;
            age_d[match_idx_q]  = '0;
          end
        end else begin
          for (int i = 0; i < NUM_VOICES; i++) begin
            if (gate_q[i] && (IDX_W'(i) != target) && (age_q[i] != AGE_MAX))
              age_d[i] = age_q[i] + 1'b1;
          end
          gate_d[target]   = 1'b1;
          note_d[target]   = cmd_note;
          vel_d[target]    = cmd_vel;
          age_d[target]    = '0;
          retrig_d[target] = 1'b1;
          steal_d          = !match_vld_q && !free_vld_q;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      overflow_q   <= 1'b0;
      state_q      <= IDLE;
      cmd_q        <= '0;
      idx_q        <= '0;
      match_vld_q  <= 1'b0;
      match_idx_q  <= '0;
      free_vld_q   <= 1'b0;
      free_idx_q   <= '0;
      oldest_vld_q <= 1'b0;
      oldest_idx_q <= '0;
      oldest_age_q <= '0;
      gate_q       <= '0;
      retrig_q     <= '0;
      steal_q      <= 1'b0;
      for (int i = 0; i < NUM_VOICES; i++) begin
        note_q[i] <= '0;
        vel_q[i]  <= '0;
        age_q[i]  <= '0;
      end
    end else begin
      // NOTE: non-blocking updates so every flop samples the pre-edge value of its neighbours.
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      overflow_q   <= overflow_d;
      state_q      <= state_d;
      cmd_q        <= cmd_d;
      idx_q        <= idx_d;
      match_vld_q  <= match_vld_d;
      match_idx_q  <= match_idx_d;
      free_vld_q   <= free_vld_d;
      free_idx_q   <= free_idx_d;
      oldest_vld_q <= oldest_vld_d;
      oldest_idx_q <= oldest_idx_d;
      oldest_age_q <= oldest_age_d;
      gate_q       <= gate_d;
      retrig_q     <= retrig_d;
      steal_q      <= steal_d;
      note_q       <= note_d;
      vel_q        <= vel_d;
      age_q        <= age_d;
    end
  end

  assign busy         = (state_q != IDLE) || !fifo_empty;
  assign overflow     = overflow_q;
  assign voice_gate   = gate_q;
  assign voice_retrig = retrig_q;
  assign steal        = steal_q;

  for (genvar g = 0; g < NUM_VOICES; g++) begin : g_pack
    assign voice_note[7*g +: 7] = note_q[g];
    assign voice_vel[8*g +: 8]  = vel_q[g];
  end

endmodule

// File: tb/tb_voice_allocator.sv
// Self-checking bench for voice_allocator: reset, latency, a directed vector table,
// stealing, FIFO overflow, STOP_ALL, mid-scan reset and a randomized model comparison.
`timescale 1ns/1ps
module tb_voice_allocator;

  localparam int NV = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          cmd_write;
  logic [15:0]   cmd_data;
  logic          ovf_clear;
  logic          busy;
  logic          overflow;
  logic [NV-1:0] voice_gate;
  logic [7*NV-1:0] voice_note;
  logic [8*NV-1:0] voice_vel;
  logic [NV-1:0] voice_retrig;
  logic          steal;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: voice table updated straight from the allocation rules.
  logic       m_gate [NV];
  logic [6:0] m_note [NV];
  logic [7:0] m_vel  [NV];
  int         m_age  [NV];

  typedef struct {
    logic [15:0] cmd;
    logic [15:0] gate;
    logic [15:0] retrig;
    logic        stl;
    int          vidx;
    logic [6:0]  note;
    logic [7:0]  vel;
  } vec_t;

  vec_t vecs [9];

  voice_allocator #(.NUM_VOICES(NV), .FIFO_DEPTH(4), .AGE_W(6)) dut (
    .clk(clk), .reset(reset), .cmd_write(cmd_write), .cmd_data(cmd_data),
    .ovf_clear(ovf_clear), .busy(busy), .overflow(overflow),
    .voice_gate(voice_gate), .voice_note(voice_note), .voice_vel(voice_vel),
    .voice_retrig(voice_retrig), .steal(steal)
  );

  always #5 clk = ~clk;

  initial begin
    #(5_000_000);
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NV; i++) begin
      m_gate[i] = 1'b0; m_note[i] = '0; m_vel[i] = '0; m_age[i] = 0;
    end
  endtask

  task automatic model_apply(input logic [15:0] c, output logic [NV-1:0] exp_retrig,
                             output logic exp_steal);
    int match = -1, free = -1, oldest = -1, t;
    int note = int'(c[14:8]);
    exp_retrig = '0;
    exp_steal  = 1'b0;
    if (!c[15] && note == 127) begin
      for (int i = 0; i < NV; i++) begin m_gate[i] = 1'b0; m_age[i] = 0; end
      return;
    end
    for (int i = 0; i < NV; i++) begin
      if (m_gate[i] && int'(m_note[i]) == note && match < 0) match = i;
      if (!m_gate[i] && free < 0) free = i;
      if (m_gate[i] && (oldest < 0 || m_age[i] > m_age[oldest])) oldest = i;
    end
    if (!c[15]) begin
      if (match >= 0) begin m_gate[match] = 1'b0; m_age[match] = 0; end
      return;
    end
    t = (match >= 0) ? match : ((free >= 0) ? free : oldest);
    exp_steal = (match < 0) && (free < 0);
    for (int i = 0; i < NV; i++)
      if (m_gate[i] && i != t) m_age[i] = (m_age[i] >= 63) ? 63 : m_age[i] + 1;
    m_gate[t] = 1'b1; m_note[t] = c[14:8]; m_vel[t] = c[7:0]; m_age[t] = 0;
    exp_retrig[t] = 1'b1;
  endtask

  function automatic logic [127:0] model_gates();
    logic [127:0] r = '0;
    for (int i = 0; i < NV; i++) r[i] = m_gate[i];
    return r;
  endfunction

  function automatic logic [127:0] model_notes();
    logic [127:0] r = '0;
    for (int i = 0; i < NV; i++) r[7*i +: 7] = m_note[i];
    return r;
  endfunction

  function automatic logic [127:0] model_vels();
    logic [127:0] r = '0;
    for (int i = 0; i < NV; i++) r[8*i +: 8] = m_vel[i];
    return r;
  endfunction

  task automatic do_reset();
    @(negedge clk); reset = 1'b0;
    @(negedge clk); reset = 1'b1;
    model_reset();
  endtask

  task automatic send(input logic [15:0] d);
    @(negedge clk); cmd_write = 1'b1; cmd_data = d;
    @(negedge clk); cmd_write = 1'b0;
  endtask

  // Returns on the first falling edge with busy low, i.e. the cycle the result pulses are visible.
  task automatic wait_idle(input string name);
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (!busy) break;
    end
    check({name, "_idle"}, busy, 0);
  endtask

  initial begin
    logic [NV-1:0]  er;
    logic           es;
    logic [127:0]   exp_n;
    logic [15:0]    c;

    reset = 1'b0; cmd_write = 1'b0; cmd_data = '0; ovf_clear = 1'b0;
    model_reset();

    // Reset held while writes arrive: everything stays at zero.
    repeat (3) begin
      @(negedge clk); cmd_write = 1'b1; cmd_data = 16'hC500;
      @(negedge clk); cmd_write = 1'b0;
    end
    check("rst_gate", voice_gate, 0);
    check("rst_note", voice_note, 0);
    check("rst_vel", voice_vel, 0);
    check("rst_retrig", voice_retrig, 0);
    check("rst_steal", steal, 0);
    check("rst_ovf", overflow, 0);
    check("rst_busy", busy, 0);
    @(negedge clk); reset = 1'b1;
    repeat (3) @(negedge clk);
    check("post_rst_busy", busy, 0);
    check("post_rst_gate", voice_gate, 0);

    // Exact latency: result appears after edge E+18, not E+17.
    @(negedge clk); cmd_write = 1'b1; cmd_data = 16'hC500;
    @(negedge clk); cmd_write = 1'b0;
    repeat (17) @(negedge clk);
    check("lat_e17_gate", voice_gate, 0);
    check("lat_e17_retrig", voice_retrig, 0);
    @(negedge clk);
    check("lat_e18_gate", voice_gate, 16'h0001);
    check("lat_e18_retrig", voice_retrig, 16'h0001);
    check("lat_e18_note0", voice_note[6:0], 7'd69);
    check("lat_e18_busy", busy, 0);
    @(negedge clk);
    check("lat_retrig_1cyc", voice_retrig, 0);

    // Directed vector table.
    vecs[0] = '{16'hC500, 16'h0001, 16'h0001, 1'b0, 0, 7'd69, 8'h00};
    vecs[1] = '{16'h4900, 16'h0001, 16'h0000, 1'b0, 0, 7'd69, 8'h00};
    vecs[2] = '{16'h450F, 16'h0000, 16'h0000, 1'b0, 0, 7'd69, 8'h00};
    vecs[3] = '{16'hC500, 16'h0001, 16'h0001, 1'b0, 0, 7'd69, 8'h00};
    vecs[4] = '{16'hA800, 16'h0003, 16'h0002, 1'b0, 1, 7'd40, 8'h00};
    vecs[5] = '{16'hBC00, 16'h0007, 16'h0004, 1'b0, 2, 7'd60, 8'h00};
    vecs[6] = '{16'hCD00, 16'h000F, 16'h0008, 1'b0, 3, 7'd77, 8'h00};
    vecs[7] = '{16'hDF00, 16'h001F, 16'h0010, 1'b0, 4, 7'd95, 8'h00};
    vecs[8] = '{16'hC57F, 16'h001F, 16'h0001, 1'b0, 0, 7'd69, 8'h7F};
    do_reset();
    for (int i = 0; i < 9; i++) begin
      send(vecs[i].cmd);
      wait_idle($sformatf("vec%0d", i));
      check($sformatf("vec%0d_gate", i), voice_gate, vecs[i].gate);
      check($sformatf("vec%0d_retrig", i), voice_retrig, vecs[i].retrig);
      check($sformatf("vec%0d_steal", i), steal, vecs[i].stl);
      check($sformatf("vec%0d_note", i), voice_note[7*vecs[i].vidx +: 7], vecs[i].note);
      check($sformatf("vec%0d_vel", i), voice_vel[8*vecs[i].vidx +: 8], vecs[i].vel);
      @(negedge clk);
      check($sformatf("vec%0d_retrig_clr", i), voice_retrig, 0);
    end

    // Oldest-voice stealing.
    do_reset();
    for (int n = 0; n < NV; n++) begin
      send({1'b1, 7'(10 + n), 8'h20});
      wait_idle("fill");
    end
    send(16'h9E40);
    wait_idle("steal");
    exp_n = '0;
    for (int i = 0; i < NV; i++) exp_n[7*i +: 7] = (i == 0) ? 7'd30 : 7'(10 + i);
    check("steal_gate", voice_gate, 16'hFFFF);
    check("steal_notes", voice_note, exp_n);
    check("steal_vel0", voice_vel[7:0], 8'h40);
    check("steal_retrig", voice_retrig, 16'h0001);
    check("steal_pulse", steal, 1);
    @(negedge clk);
    check("steal_pulse_clr", steal, 0);

    // Burst of six writes into a 4-deep FIFO; clear on the drop cycle must lose to the set.
    do_reset();
    for (int k = 0; k < 6; k++) begin
      @(negedge clk); cmd_write = 1'b1; cmd_data = {1'b1, 7'(50 + k), 8'h10};
      ovf_clear = (k == 5);
    end
    @(negedge clk); cmd_write = 1'b0; ovf_clear = 1'b0;
    check("ovf_set", overflow, 1);
    check("ovf_busy", busy, 1);
    wait_idle("burst");
    exp_n = '0;
    for (int i = 0; i < 5; i++) exp_n[7*i +: 7] = 7'(50 + i);
    check("burst_gate", voice_gate, 16'h001F);
    check("burst_notes", voice_note, exp_n);
    @(negedge clk); ovf_clear = 1'b1;
    @(negedge clk); ovf_clear = 1'b0;
    check("ovf_clear", overflow, 0);

    // STOP_ALL completes two edges after the write; notes retained.
    @(negedge clk); cmd_write = 1'b1; cmd_data = 16'h7F00;
    @(negedge clk); cmd_write = 1'b0;
    @(negedge clk);
    check("stopall_e1_gate", voice_gate, 16'h001F);
    @(negedge clk);
    check("stopall_gate", voice_gate, 0);
    check("stopall_notes", voice_note, exp_n);
    check("stopall_retrig", voice_retrig, 0);
    check("stopall_steal", steal, 0);
    check("stopall_busy", busy, 0);

    // Reset in the middle of a scan.
    send(16'hC164);
    repeat (5) @(negedge clk);
    check("midscan_busy", busy, 1);
    reset = 1'b0;
    #1;
    check("midscan_rst_note", voice_note, 0);
    check("midscan_rst_busy", busy, 0);
    @(negedge clk); reset = 1'b1;
    repeat (25) @(negedge clk);
    check("midscan_discard_gate", voice_gate, 0);
    check("midscan_discard_busy", busy, 0);

    // Randomized commands against the reference model.
    do_reset();
    for (int it = 0; it < 150; it++) begin
      if ($urandom_range(0, 99) < 4) c = 16'h7F00;
      else begin
        c[15]   = ($urandom_range(0, 99) < 68);
        c[14:8] = ($urandom_range(0, 19) == 0) ? 7'd127 : 7'($urandom_range(0, 23));
        c[7:0]  = 8'($urandom);
      end
      send(c);
      model_apply(c, er, es);
      wait_idle($sformatf("rnd%0d", it));
      check($sformatf("rnd%0d_gate", it), voice_gate, model_gates());
      check($sformatf("rnd%0d_notes", it), voice_note, model_notes());
      check($sformatf("rnd%0d_vels", it), voice_vel, model_vels());
      check($sformatf("rnd%0d_retrig", it), voice_retrig, er);
      check($sformatf("rnd%0d_steal", it), steal, es);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
